// File: rtl/bullet_pkg.sv
// Shared constants and types for the bullet scheduler slice.
// Defaults, counter widths, owner encoding and the launch bus layout.
package bullet_pkg;

    localparam int NUM_SLOTS    = 4;
    localparam int MAX_PER_TANK = 2;
    localparam int COOLDOWN     = 15;
    localparam int LIFETIME     = 300;

    localparam int LIFE_W = 10;
    localparam int CD_W   = $clog2(COOLDOWN + 1);

    localparam logic TANK1 = 1'b0;
    localparam logic TANK2 = 1'b1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] angle;
    } launch_t;

endpackage

// File: rtl/bullet_scheduler_if.sv
// Bus between the tank controllers / collision logic and the bullet scheduler.
// master = tank and collision side, slave = scheduler side.
interface bullet_scheduler_if #(
    parameter int N = bullet_pkg::NUM_SLOTS
);
    logic [1:0]   game_end;
    logic [1:0]   shoot_req;
    logic [9:0]   tank1_x;
    logic [9:0]   tank1_y;
    logic [9:0]   tank2_x;
    logic [9:0]   tank2_y;
    logic [5:0]   angle1;
    logic [5:0]   angle2;
    logic [N-1:0] slot_kill;
    logic [N-1:0] slot_valid;
    logic [N-1:0] slot_owner;
    logic [N-1:0] slot_load;
    logic [9:0]   load_x;
    logic [9:0]   load_y;
    logic [5:0]   load_angle;
    logic [1:0]   grant;

    modport master (
        output game_end, shoot_req, tank1_x, tank1_y, tank2_x, tank2_y,
               angle1, angle2, slot_kill,
        input  slot_valid, slot_owner, slot_load, load_x, load_y, load_angle, grant
    );

    modport slave (
        input  game_end, shoot_req, tank1_x, tank1_y, tank2_x, tank2_y,
               angle1, angle2, slot_kill,
        output slot_valid, slot_owner, slot_load, load_x, load_y, load_angle, grant
    );

endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: valid, owner and life counter; frees on kill or life expiry.
// Load takes effect at the edge it is asserted; clear overrides everything.
module bullet_slot #(
    parameter int LIFETIME = bullet_pkg::LIFETIME
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic load_i,
    input  logic owner_in_i,
    input  logic kill_i,
    input  logic clear_i,
    output logic valid_o,
    output logic owner_o
);
    import bullet_pkg::*;

    logic              valid_q, valid_d;
    logic              owner_q, owner_d;
    logic [LIFE_W-1:0] life_q,  life_d;

    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        life_d  = life_q;
        if (clear_i) begin
            valid_d = 1'b0;
            owner_d = TANK1;
            life_d  = '0;
        end else if (valid_q) begin
            // kill and expiry on the same edge collapse into a single free
            if (kill_i || life_q == LIFE_W'(1)) begin
                valid_d = 1'b0;
                life_d  = '0;
            end else begin
                life_d  = life_q - LIFE_W'(1);
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            owner_d = owner_in_i;
            life_d  = LIFE_W'(LIFETIME);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            owner_q <= TANK1;
            life_q  <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            life_q  <= life_d;
        end
    end

    assign valid_o = valid_q;
    assign owner_o = owner_q;

endmodule

// File: rtl/bullet_scheduler.sv
// Turns per-tank fire edges into bullet launches into a shared slot pool, with cooldown, ammo cap and round-robin.
// Fire event at edge k -> grant/slot_load registered at edge k+1 (k+2 for the contention loser).
module bullet_scheduler #(
    parameter int NUM_SLOTS    = bullet_pkg::NUM_SLOTS,
    parameter int MAX_PER_TANK = bullet_pkg::MAX_PER_TANK,
    parameter int COOLDOWN     = bullet_pkg::COOLDOWN,
    parameter int LIFETIME     = bullet_pkg::LIFETIME
) (
    input  logic               frame_clk,
    input  logic               Reset,
    bullet_scheduler_if.slave  bus
);
    import bullet_pkg::*;

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    // Counts frames until a new fire event is accepted; the extra two frames
    // of pending and arbitration put the earliest regrant exactly COOLDOWN after a grant.
    localparam int CD_LOAD = COOLDOWN - 2;

    logic [1:0]                  req_prev_q;
    logic [1:0]                  pending_q, pending_d;
    logic                        rr_q, rr_d;
    logic [1:0][CD_W-1:0]        cd_q, cd_d;
    logic [1:0]                  grant_q, grant_d;
    logic [NUM_SLOTS-1:0]        load_oh_q, load_oh_d;
    launch_t                     launch_q, launch_d;

    logic [NUM_SLOTS-1:0]        valid, owner, free_oh;
    logic [1:0][CNT_W-1:0]       live;
    logic [1:0]                  fire, elig, cand;
    logic                        round_over, any_free, found, contend, win, gnt_vld;

    assign round_over = |bus.game_end;
    assign any_free   = ~&valid;
    assign fire       = bus.shoot_req & ~req_prev_q & {2{~round_over}};

    always_comb begin
        live    = '0;
        free_oh = '0;
        found   = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (valid[s]) begin
                live[owner[s]] = live[owner[s]] + CNT_W'(1);
            end else if (!found) begin
                free_oh[s] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            elig[t] = (cd_q[t] == '0) && (live[t] < CNT_W'(MAX_PER_TANK)) && any_free;
        end
    end

    assign cand    = pending_q & elig & {2{~round_over}};
    assign contend = &cand;
    assign win     = contend ? rr_q : cand[1];
    assign gnt_vld = |cand;

    always_comb begin
        grant_d   = gnt_vld ? (win ? 2'b10 : 2'b01) : 2'b00;
        load_oh_d = gnt_vld ? free_oh : '0;
        launch_d  = '0;
        if (gnt_vld) begin
            launch_d = win ? '{x: bus.tank2_x, y: bus.tank2_y, angle: bus.angle2}
                           : '{x: bus.tank1_x, y: bus.tank1_y, angle: bus.angle1};
        end
        // the contention loser stays pending; ineligible requests are dropped
        pending_d = round_over ? 2'b00 : (((pending_q & ~grant_d) | fire) & elig);
        rr_d      = round_over ? 1'b0 : (contend ? ~win : rr_q);
        for (int t = 0; t < 2; t++) begin
            if (round_over)            cd_d[t] = '0;
            else if (grant_d[t])       cd_d[t] = CD_W'(CD_LOAD);
            else if (cd_q[t] != '0)    cd_d[t] = cd_q[t] - CD_W'(1);
            else                       cd_d[t] = '0;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            req_prev_q <= '0;
            pending_q  <= '0;
            rr_q       <= 1'b0;
            cd_q       <= '0;
            grant_q    <= '0;
            load_oh_q  <= '0;
            launch_q   <= '0;
        end else begin
            req_prev_q <= bus.shoot_req;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            cd_q       <= cd_d;
            grant_q    <= grant_d;
            load_oh_q  <= load_oh_d;
            launch_q   <= launch_d;
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .load_i     (load_oh_d[s]),
            .owner_in_i (win ? TANK2 : TANK1),
            .kill_i     (bus.slot_kill[s]),
            .clear_i    (round_over),
            .valid_o    (valid[s]),
            .owner_o    (owner[s])
        );
    end

    assign bus.slot_valid = valid;
    assign bus.slot_owner = owner;
    assign bus.slot_load  = load_oh_q;
    assign bus.grant      = grant_q;
    assign bus.load_x     = launch_q.x;
    assign bus.load_y     = launch_q.y;
    assign bus.load_angle = launch_q.angle;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: single shot, cooldown, contention, pool full, ammo cap, round end.
module tb_bullet_scheduler;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_run     = 0;
    int   n_fail    = 0;

    bullet_scheduler_if bus();

    bullet_scheduler dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic hard_reset();
        bus.shoot_req = '0;
        bus.slot_kill = '0;
        bus.game_end  = '0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // raise shoot_req[t] so the fire event lands on the next edge, then release
    task automatic press(input int t);
        bus.shoot_req[t] = 1'b1;
        tick();
        bus.shoot_req[t] = 1'b0;
    endtask

    initial begin
        bus.tank1_x = 10'd100; bus.tank1_y = 10'd200; bus.angle1 = 6'd7;
        bus.tank2_x = 10'd500; bus.tank2_y = 10'd300; bus.angle2 = 6'd30;
        bus.shoot_req = '0;
        bus.slot_kill = '0;
        bus.game_end  = '0;

        // reset state
        #2;
        chk("rst_valid", bus.slot_valid, 4'b0000);
        chk("rst_owner", bus.slot_owner, 4'b0000);
        chk("rst_load",  bus.slot_load,  4'b0000);
        chk("rst_grant", bus.grant,      2'b00);
        chk("rst_lx",    bus.load_x,     10'd0);
        chk("rst_ly",    bus.load_y,     10'd0);
        chk("rst_la",    bus.load_angle, 6'd0);
        hard_reset();

        // single shot
        press(0);
        chk("ss_pend_grant", bus.grant, 2'b00);
        tick();
        chk("ss_grant",  bus.grant,         2'b01);
        chk("ss_load",   bus.slot_load,     4'b0001);
        chk("ss_owner0", bus.slot_owner[0], 1'b0);
        chk("ss_lx",     bus.load_x,        10'd100);
        chk("ss_ly",     bus.load_y,        10'd200);
        chk("ss_la",     bus.load_angle,    6'd7);
        chk("ss_valid",  bus.slot_valid,    4'b0001);
        tick();
        chk("ss_grant_pulse", bus.grant,     2'b00);
        chk("ss_load_pulse",  bus.slot_load, 4'b0000);
        tick(298);
        chk("ss_life_299", bus.slot_valid, 4'b0001);
        tick();
        chk("ss_life_300", bus.slot_valid, 4'b0000);

        // cooldown
        hard_reset();
        press(0);
        tick();
        chk("cd_first", bus.grant, 2'b01);
        tick(4);
        press(0);
        tick();
        chk("cd_drop", bus.grant, 2'b00);
        tick(7);
        press(0);
        tick();
        chk("cd_regrant",  bus.grant,      2'b01);
        chk("cd_slot1",    bus.slot_load,  4'b0010);
        chk("cd_valid",    bus.slot_valid, 4'b0011);

        // asynchronous reset mid-flight
        Reset = 1'b1;
        #1;
        chk("arst_valid", bus.slot_valid, 4'b0000);
        chk("arst_grant", bus.grant,      2'b00);
        chk("arst_load",  bus.slot_load,  4'b0000);
        tick();
        Reset = 1'b0;
        tick();

        // contention, then repeat with rr favouring tank 2, filling the pool
        bus.shoot_req = 2'b11;
        tick();
        bus.shoot_req = 2'b00;
        chk("ct_pend", bus.grant, 2'b00);
        tick();
        chk("ct1_grant", bus.grant,     2'b01);
        chk("ct1_load",  bus.slot_load, 4'b0001);
        tick();
        chk("ct2_grant", bus.grant,         2'b10);
        chk("ct2_load",  bus.slot_load,     4'b0010);
        chk("ct2_owner", bus.slot_owner[1], 1'b1);
        chk("ct2_lx",    bus.load_x,        10'd500);
        chk("ct2_la",    bus.load_angle,    6'd30);
        tick(13);
        bus.shoot_req = 2'b11;
        tick();
        bus.shoot_req = 2'b00;
        tick();
        chk("ct3_grant", bus.grant,     2'b10);
        chk("ct3_load",  bus.slot_load, 4'b0100);
        tick();
        chk("ct4_grant", bus.grant,      2'b01);
        chk("ct4_load",  bus.slot_load,  4'b1000);
        chk("pf_valid",  bus.slot_valid, 4'b1111);
        chk("pf_owner",  bus.slot_owner, 4'b0110);

        // pool full: presses dropped; kill with press on the same edge drops the press
        tick(21);
        bus.shoot_req = 2'b11;
        tick();
        bus.shoot_req = 2'b00;
        tick();
        chk("pf_drop_a", bus.grant, 2'b00);
        tick();
        chk("pf_drop_b", bus.grant, 2'b00);
        bus.slot_kill = 4'b0001;
        bus.shoot_req = 2'b01;
        tick();
        bus.slot_kill = 4'b0000;
        bus.shoot_req = 2'b00;
        tick();
        chk("pf_same_edge", bus.grant,      2'b00);
        chk("pf_freed",     bus.slot_valid, 4'b1110);
        press(0);
        tick();
        chk("pf_reuse_grant", bus.grant,      2'b01);
        chk("pf_reuse_load",  bus.slot_load,  4'b0001);
        chk("pf_reuse_valid", bus.slot_valid, 4'b1111);

        // ammo limit
        hard_reset();
        press(0);
        tick();
        chk("am1_load", bus.slot_load, 4'b0001);
        tick(18);
        press(0);
        tick();
        chk("am2_load", bus.slot_load, 4'b0010);
        tick(18);
        press(0);
        tick();
        chk("am3_drop", bus.grant, 2'b00);
        bus.slot_kill = 4'b0001;
        tick();
        bus.slot_kill = 4'b0000;
        chk("am_kill", bus.slot_valid, 4'b0010);
        press(0);
        tick();
        chk("am_reuse_grant", bus.grant,     2'b01);
        chk("am_reuse_load",  bus.slot_load, 4'b0001);

        // round end with three live bullets and tank 2 pending
        hard_reset();
        bus.shoot_req = 2'b11;
        tick();
        bus.shoot_req = 2'b00;
        tick(2);
        tick(12);
        press(0);
        tick();
        chk("re_third_load", bus.slot_load,  4'b0100);
        chk("re_live3",      bus.slot_valid, 4'b0111);
        bus.shoot_req[1] = 1'b1;
        tick();
        bus.shoot_req[1] = 1'b0;
        bus.game_end = 2'b01;
        tick();
        chk("re_valid_clr", bus.slot_valid, 4'b0000);
        chk("re_no_grant",  bus.grant,      2'b00);
        chk("re_no_load",   bus.slot_load,  4'b0000);
        tick();
        chk("re_no_grant2", bus.grant, 2'b00);
        bus.game_end = 2'b00;
        press(0);
        tick();
        chk("re_after_grant", bus.grant,     2'b01);
        chk("re_after_load",  bus.slot_load, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Shares a fixed pool of bullet slots between the two tanks. Turns each tank's level-type ShootBullet into at most one bullet launch, enforcing per-tank cooldown and ammo limits. Round-robin arbitrates simultaneous fire requests and retires bullets on lifetime expiry or hit. Sits between the two tank controllers and the bullet motion units; all state advances once per frame_clk.

## Interface
Parameters:
- NUM_SLOTS, 4: total bullet slots shared by both tanks.
- MAX_PER_TANK, 2: maximum live bullets owned by one tank.
- COOLDOWN, 15: frames a tank must wait after a grant before its next grant.
- LIFETIME, 300: frames a bullet stays live; fits in 10 bits.

Ports:
- frame_clk  in  1  clock (one edge per video frame).
- Reset  in  1  asynchronous, active-high.
- game_end  in  2  nonzero means round over; clears and freezes the scheduler.
- shoot_req  in  2  ShootBullet level, bit 0 = tank 1, bit 1 = tank 2.
- tank1_x, tank1_y, tank2_x, tank2_y  in  10 each  tank centre positions.
- angle1, angle2  in  6 each  tank angle indices, 0..44.
- slot_kill  in  NUM_SLOTS  per-slot retire pulse from collision logic.
- slot_valid  out  NUM_SLOTS  slot holds a live bullet.
- slot_owner  out  NUM_SLOTS  per slot: 0 = tank 1, 1 = tank 2; meaningful only when valid.
- slot_load  out  NUM_SLOTS  one-hot, one-frame pulse: load the launch bus into this slot.
- load_x, load_y  out  10 each  launch position, the granted tank's centre.
- load_angle  out  6  granted tank's angle.
- grant  out  2  one-frame pulse identifying the tank just granted.

## Operation
- Edge detect: a fire event for tank i is a 0→1 transition of shoot_req[i] between consecutive frame_clk samples. Holding the key fires once.
- Eligibility for tank i: cooldown[i] is 0, live count owned by i is below MAX_PER_TANK, and at least one slot is free.
- Request handling:
  - A fire event from an eligible tank sets pending[i].
  - A fire event from an ineligible tank is dropped, not queued.
- Arbitration: at most one grant per frame.
  - If both tanks are pending, the round-robin pointer rr picks the winner. rr then points to the other tank.
  - The loser stays pending. It is granted next frame if still eligible; otherwise its pending bit is cleared.
- Grant actions:
  - The lowest-index free slot is loaded.
  - slot_valid set, slot_owner written, life counter set to LIFETIME.
  - cooldown set to COOLDOWN.
  - pending[i] cleared.
  - grant, slot_load and the launch bus are driven.
- Per slot:
  - A live slot's life counter decrements each frame. On the edge where it reaches 0, valid clears.
  - A slot_kill on a live slot clears valid at the next edge. A slot_kill on a free slot is ignored.
  - If kill and expiry coincide, the slot is freed once.
- A slot freed on edge k is first available for loading on edge k+1.
- Cooldown counters decrement toward 0 and saturate there.
- While game_end is nonzero:
  - All valid, pending and cooldown state clears and rr resets to 0.
  - Edge-detect history still tracks shoot_req, and no fire events are accepted.

## Timing
- Reset values: slot_valid=0, slot_owner=0, slot_load=0, grant=0, load_x=0, load_y=0, load_angle=0, rr=0, all counters 0.
- All outputs are registered.
- Latency, uncontended: a fire event sampled at edge k produces grant/slot_load high from edge k+1 to k+2, and slot_valid high from edge k+1.
- Latency, contended: the losing tank's grant occurs at edge k+2.
- Launch bus is valid only during the slot_load pulse. It is sampled from the tank inputs on the arbitration edge.
- A bullet loaded at edge g deasserts valid at edge g+LIFETIME.
- Earliest regrant of the same tank is edge g+COOLDOWN.
- Reset mid-flight clears everything immediately, with no pulse emitted.

## Structure
- Package bullet_pkg holds:
  - NUM_SLOTS, MAX_PER_TANK, COOLDOWN and LIFETIME defaults.
  - Life and cooldown counter widths.
  - The owner encoding constants TANK1=0 and TANK2=1.
- Sub-module bullet_slot, instantiated NUM_SLOTS times, holds valid, owner and the life counter. Its inputs are load, owner_in, kill and clear.
- The top level holds edge detectors, pending bits, cooldowns, per-tank live counts, the rr arbiter, the priority encoder and the launch mux.

## Test plan
- **Single shot:** after reset, pulse shoot_req[0] for 1 frame.
  - grant=01 and slot_load=0001 one frame later.
  - slot_owner[0]=0; load_x/load_y/load_angle equal the tank 1 values.
  - slot_valid[0] falls 300 frames after the load.
- **Cooldown:** press shoot_req[0], then press again 5 frames later.
  - The second press is dropped.
  - A press at 15 frames after the grant is granted into slot 1.
- **Contention:** both tanks rise on the same edge from reset.
  - Frame 1: grant=01, slot 0.
  - Frame 2: grant=10, slot 1.
  - Repeat after cooldown: tank 2 wins first.
- **Ammo limit:** tank 1 fires 3 times, spaced 20 frames apart.
  - The third shot is dropped (2 live).
  - Pulse slot_kill for tank 1's slot 0, and the next tank 1 press reuses slot 0.
- **Pool full:** fill all 4 slots (2 per tank).
  - Further presses are dropped.
  - A kill and a press on the same edge: the press is dropped; a press one frame later loads the freed slot.
- **Round end:** assert game_end=01 with 3 live bullets and a pending request.
  - slot_valid becomes 0000 next edge and no grant is issued.
  - After release, an immediate press is granted with no cooldown.
